// File: rtl/calc_sequencer.sv
// calc_sequencer
//
// Sequencer between the 16-bit operand/opcode capture stage and the
// byte-wide output bus of the calculator datapath. A one-cycle start pulse
// latches both operands and the opcode. The block then runs one of three
// kinds of operation:
//   - a single-cycle ALU op,
//   - a 16-iteration shift-add multiply,
//   - a 16-iteration restoring divide/modulo.
// The 16-bit result is returned as two bytes, low byte first, under a
// valid/ready handshake.
//
// Ports:
//   clock      - sole clock, rising-edge
//   reset      - synchronous, active-high
//   start      - one-cycle request pulse (honoured only in IDLE)
//   num1       - operand A (16 bits), sampled on an accepted start
//   num2       - operand B (16 bits), sampled on an accepted start
//   op         - opcode (4 bits), sampled on an accepted start
//   out_ready  - consumer can take the current byte
//   out_data   - result byte (forced to 0 while out_valid is low)
//   out_valid  - out_data is valid
//   out_last   - current byte is the high byte
//   busy       - high in every state except IDLE
//   error      - last operation divided by zero or used an illegal opcode

module calc_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] num1,
    input  logic [15:0] num2,
    input  logic [3:0]  op,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        busy,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        OUT_LO = 2'd2,
        OUT_HI = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;
    localparam logic [3:0] OP_DIV = 4'd6;
    localparam logic [3:0] OP_MOD = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    state_t      state;
    state_t      state_next;

    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [3:0]  op_reg;
    logic [15:0] result;
    logic [15:0] rem;
    logic [4:0]  count;
    logic        error_reg;

    logic        is_div;
    logic        is_iter;
    logic        div_zero;
    logic        illegal;
    logic        last_iter;

    logic [15:0] alu_res;
    logic [15:0] mul_next;
    logic [16:0] rem_shift;
    logic        div_ge;
    logic [15:0] rem_sub;
    logic [15:0] rem_next;
    logic [15:0] quo_next;

    // Opcode classification
    always_comb begin
        is_div    = (op_reg == OP_DIV) || (op_reg == OP_MOD);
        is_iter   = (op_reg == OP_MUL) || is_div;
        div_zero  = is_div && (b_reg == 16'd0);
        illegal   = (op_reg >= 4'd10);
        last_iter = (count == 5'd15);
    end

    // Single-cycle ALU
    always_comb begin
        alu_res = 16'd0;
        case (op_reg)
            OP_ADD:  alu_res = a_reg + b_reg;
            OP_SUB:  alu_res = a_reg - b_reg;
            OP_AND:  alu_res = a_reg & b_reg;
            OP_OR:   alu_res = a_reg | b_reg;
            OP_XOR:  alu_res = a_reg ^ b_reg;
            OP_SHL:  alu_res = a_reg << b_reg[3:0];
            OP_SHR:  alu_res = a_reg >> b_reg[3:0];
            default: alu_res = 16'd0;
        endcase
    end

    // One iteration of the shift-add multiplier and the restoring divider.
    // Multiply: result accumulates A while A shifts left and B shifts right,
    // so b_reg[0] is always the multiplier bit for the current weight.
    // Divide: a_reg doubles as the dividend shifter and the quotient
    // register. Its MSB feeds the partial remainder and each quotient bit
    // enters at the LSB. After 16 iterations a_reg holds the quotient and
    // rem holds the remainder.
    always_comb begin
        mul_next  = result + (b_reg[0] ? a_reg : 16'd0);
        rem_shift = {rem, a_reg[15]};
        div_ge    = (rem_shift >= {1'b0, b_reg});
        // When div_ge holds, the difference is below B, so it fits in 16
        // bits and the discarded carry is never needed.
        rem_sub   = rem_shift[15:0] - b_reg;
        rem_next  = div_ge ? rem_sub : rem_shift[15:0];
        quo_next  = {a_reg[14:0], div_ge};
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode. Outputs depend only on registered
    // state, so out_ready never reaches out_valid combinationally.
    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = 8'd0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (!is_iter || div_zero || last_iter) begin
                    state_next = OUT_LO;
                end
            end
            OUT_LO: begin
                out_valid = 1'b1;
                out_data  = result[7:0];
                if (out_ready) begin
                    state_next = OUT_HI;
                end
            end
            OUT_HI: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = result[15:8];
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture and execution datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg     <= 16'd0;
            b_reg     <= 16'd0;
            op_reg    <= 4'd0;
            result    <= 16'd0;
            rem       <= 16'd0;
            count     <= 5'd0;
            error_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= num1;
                        b_reg     <= num2;
                        op_reg    <= op;
                        result    <= 16'd0;
                        rem       <= 16'd0;
                        count     <= 5'd0;
                        error_reg <= 1'b0;
                    end
                end
                EXEC: begin
                    if (div_zero) begin
                        result    <= 16'hFFFF;
                        error_reg <= 1'b1;
                    end else if (illegal) begin
                        result    <= 16'h0000;
                        error_reg <= 1'b1;
                    end else if (op_reg == OP_MUL) begin
                        result <= mul_next;
                        a_reg  <= a_reg << 1;
                        b_reg  <= b_reg >> 1;
                        count  <= count + 5'd1;
                    end else if (is_div) begin
                        a_reg <= quo_next;
                        rem   <= rem_next;
                        count <= count + 5'd1;
                        if (last_iter) begin
                            result <= (op_reg == OP_DIV) ? quo_next : rem_next;
                        end
                    end else begin
                        result <= alu_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign error = error_reg;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer
//
// Directed testbench for calc_sequencer. Cycle 0 is the cycle in which
// start is high. Every observation is taken 1 time unit after a rising
// clock edge. The observed vector is {out_valid, out_last, busy, error,
// out_data}, so its top hex nibble reads 0 = idle, 2 = exec, A = low byte,
// E = high byte, plus 1 when error is set.

module tb_calc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num1;
    logic [15:0] num2;
    logic [3:0]  op;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        error;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [11:0] obs;
    assign obs = {out_valid, out_last, busy, error, out_data};

    always #5 clock = ~clock;

    calc_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .num1      (num1),
        .num2      (num2),
        .op        (op),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy),
        .error     (error)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse start for cycle 0 and return in cycle 1 with the operands
    // scrambled, so that the result can only come from the latched copies.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [3:0] o);
        start = 1'b1;
        num1  = a;
        num2  = b;
        op    = o;
        tick();
        start = 1'b0;
        num1  = ~a;
        num2  = ~b;
        op    = ~o;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        num1      = 16'hA5A5;
        num2      = 16'h5A5A;
        op        = 4'd0;
        out_ready = 1'b0;
        tick();
        tick();
        n_cmp++; if (obs !== 12'h000) begin n_fail++; $display("FAIL reset_held: got %h expected %h", obs, 12'h000); end
        reset = 1'b0;
        tick();
        n_cmp++; if (obs !== 12'h000) begin n_fail++; $display("FAIL reset_release: got %h expected %h", obs, 12'h000); end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        n_cmp++; if (obs !== 12'h000) begin n_fail++; $display("FAIL add_c0: got %h expected %h", obs, 12'h000); end
        launch(16'h12FF, 16'h0001, 4'd0);
        n_cmp++; if (obs !== 12'h200) begin n_fail++; $display("FAIL add_c1: got %h expected %h", obs, 12'h200); end
        tick();
        n_cmp++; if (obs !== 12'hA00) begin n_fail++; $display("FAIL add_c2: got %h expected %h", obs, 12'hA00); end
        tick();
        n_cmp++; if (obs !== 12'hE13) begin n_fail++; $display("FAIL add_c3: got %h expected %h", obs, 12'hE13); end
        tick();
        n_cmp++; if (obs !== 12'h000) begin n_fail++; $display("FAIL add_c4: got %h expected %h", obs, 12'h000); end
    endtask

    // Start held during the OUT_HI transfer must be ignored. The same start
    // still high in cycle 4 must launch an xor: 00F0 ^ 0FF0 = 0F00.
    task automatic test_back_to_back();
        out_ready = 1'b1;
        launch(16'h0001, 16'h0002, 4'd0);
        tick();
        n_cmp++; if (obs !== 12'hA03) begin n_fail++; $display("FAIL b2b_lo: got %h expected %h", obs, 12'hA03); end
        tick();
        n_cmp++; if (obs !== 12'hE00) begin n_fail++; $display("FAIL b2b_hi: got %h expected %h", obs, 12'hE00); end
        start = 1'b1;
        num1  = 16'hFFFF;
        num2  = 16'hFFFF;
        op    = 4'd1;
        tick();
        n_cmp++; if (obs !== 12'h000) begin n_fail++; $display("FAIL b2b_start_dropped: got %h expected %h", obs, 12'h000); end
        num1 = 16'h00F0;
        num2 = 16'h0FF0;
        op   = 4'd4;
        tick();
        start = 1'b0;
        n_cmp++; if (obs !== 12'h200) begin n_fail++; $display("FAIL b2b_accept: got %h expected %h", obs, 12'h200); end
        tick();
        n_cmp++; if (obs !== 12'hA00) begin n_fail++; $display("FAIL b2b_xor_lo: got %h expected %h", obs, 12'hA00); end
        tick();
        n_cmp++; if (obs !== 12'hE0F) begin n_fail++; $display("FAIL b2b_xor_hi: got %h expected %h", obs, 12'hE0F); end
        tick();
        n_cmp++; if (obs !== 12'h000) begin n_fail++; $display("FAIL b2b_idle: got %h expected %h", obs, 12'h000); end
    endtask

    // 300 * 250 = 75000, and 75000 mod 65536 = 9464 = 16'h24F8.
    task automatic test_mul_backpressure();
        out_ready = 1'b0;
        launch(16'd300, 16'd250, 4'd5);
        n_cmp++; if (obs !== 12'h200) begin n_fail++; $display("FAIL mul_c1: got %h expected %h", obs, 12'h200); end
        repeat (15) tick();
        n_cmp++; if (obs !== 12'h200) begin n_fail++; $display("FAIL mul_c16: got %h expected %h", obs, 12'h200); end
        for (int c = 17; c <= 19; c++) begin
            tick();
            n_cmp++; if (obs !== 12'hAF8) begin n_fail++; $display("FAIL mul_hold_c%0d: got %h expected %h", c, obs, 12'hAF8); end
        end
        tick();
        out_ready = 1'b1;
        n_cmp++; if (obs !== 12'hAF8) begin n_fail++; $display("FAIL mul_c20: got %h expected %h", obs, 12'hAF8); end
        tick();
        n_cmp++; if (obs !== 12'hE24) begin n_fail++; $display("FAIL mul_c21: got %h expected %h", obs, 12'hE24); end
        tick();
        n_cmp++; if (obs !== 12'h000) begin n_fail++; $display("FAIL mul_c22: got %h expected %h", obs, 12'h000); end
    endtask

    task automatic test_divmod(input logic [3:0] o, input logic [15:0] exp);
        out_ready = 1'b1;
        launch(16'd1000, 16'd7, o);
        repeat (15) tick();
        n_cmp++; if (obs !== 12'h200) begin n_fail++; $display("FAIL divmod%0d_c16: got %h expected %h", o, obs, 12'h200); end
        tick();
        n_cmp++; if (obs !== {4'hA, exp[7:0]}) begin n_fail++; $display("FAIL divmod%0d_c17: got %h expected %h", o, obs, {4'hA, exp[7:0]}); end
        tick();
        n_cmp++; if (obs !== {4'hE, exp[15:8]}) begin n_fail++; $display("FAIL divmod%0d_c18: got %h expected %h", o, obs, {4'hE, exp[15:8]}); end
        tick();
        n_cmp++; if (obs !== 12'h000) begin n_fail++; $display("FAIL divmod%0d_c19: got %h expected %h", o, obs, 12'h000); end
    endtask

    task automatic test_errors();
        out_ready = 1'b1;
        launch(16'd5, 16'd0, 4'd6);
        n_cmp++; if (obs !== 12'h200) begin n_fail++; $display("FAIL dz_c1: got %h expected %h", obs, 12'h200); end
        tick();
        n_cmp++; if (obs !== 12'hBFF) begin n_fail++; $display("FAIL dz_c2: got %h expected %h", obs, 12'hBFF); end
        tick();
        n_cmp++; if (obs !== 12'hFFF) begin n_fail++; $display("FAIL dz_c3: got %h expected %h", obs, 12'hFFF); end
        tick();
        n_cmp++; if (obs !== 12'h100) begin n_fail++; $display("FAIL dz_error_held: got %h expected %h", obs, 12'h100); end
        launch(16'h1234, 16'h0055, 4'd12);
        n_cmp++; if (obs !== 12'h200) begin n_fail++; $display("FAIL ill_c1_cleared: got %h expected %h", obs, 12'h200); end
        tick();
        n_cmp++; if (obs !== 12'hB00) begin n_fail++; $display("FAIL ill_c2: got %h expected %h", obs, 12'hB00); end
        tick();
        n_cmp++; if (obs !== 12'hF00) begin n_fail++; $display("FAIL ill_c3: got %h expected %h", obs, 12'hF00); end
        tick();
        n_cmp++; if (obs !== 12'h100) begin n_fail++; $display("FAIL ill_error_held: got %h expected %h", obs, 12'h100); end
        launch(16'h0003, 16'h0004, 4'd0);
        n_cmp++; if (obs !== 12'h200) begin n_fail++; $display("FAIL clr_c1: got %h expected %h", obs, 12'h200); end
        tick();
        n_cmp++; if (obs !== 12'hA07) begin n_fail++; $display("FAIL clr_c2: got %h expected %h", obs, 12'hA07); end
        tick();
        n_cmp++; if (obs !== 12'hE00) begin n_fail++; $display("FAIL clr_c3: got %h expected %h", obs, 12'hE00); end
        tick();
        n_cmp++; if (obs !== 12'h000) begin n_fail++; $display("FAIL clr_c4: got %h expected %h", obs, 12'h000); end
    endtask

    // 3 * 5 = 15. The cycle-5 start (an add of FFFF + FFFF) must not
    // disturb the product or add extra bytes.
    task automatic test_busy_ignore();
        int xfers;
        int first_valid;
        xfers       = 0;
        first_valid = -1;
        out_ready   = 1'b1;
        launch(16'd3, 16'd5, 4'd5);
        for (int c = 1; c <= 24; c++) begin
            if (out_valid && first_valid < 0) first_valid = c;
            if (out_valid && out_ready) begin
                if (xfers == 0) begin
                    n_cmp++; if (obs !== 12'hA0F) begin n_fail++; $display("FAIL busy_byte0: got %h expected %h", obs, 12'hA0F); end
                end else if (xfers == 1) begin
                    n_cmp++; if (obs !== 12'hE00) begin n_fail++; $display("FAIL busy_byte1: got %h expected %h", obs, 12'hE00); end
                end
                xfers++;
            end
            if (c == 5) begin
                start = 1'b1;
                num1  = 16'hFFFF;
                num2  = 16'hFFFF;
                op    = 4'd0;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        n_cmp++; if (xfers !== 2) begin n_fail++; $display("FAIL busy_xfer_count: got %0d expected %0d", xfers, 2); end
        n_cmp++; if (first_valid !== 17) begin n_fail++; $display("FAIL busy_first_valid: got %0d expected %0d", first_valid, 17); end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen      = 0;
        out_ready = 1'b1;
        launch(16'd1000, 16'd7, 4'd6);
        repeat (8) tick();
        n_cmp++; if (obs !== 12'h200) begin n_fail++; $display("FAIL rmid_c9: got %h expected %h", obs, 12'h200); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (obs !== 12'h000) begin n_fail++; $display("FAIL rmid_c10: got %h expected %h", obs, 12'h000); end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid || busy) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rmid_quiet: got %0d expected %0d", seen, 0); end
        launch(16'h0000, 16'h0001, 4'd1);
        n_cmp++; if (obs !== 12'h200) begin n_fail++; $display("FAIL rmid_sub_c1: got %h expected %h", obs, 12'h200); end
        tick();
        n_cmp++; if (obs !== 12'hAFF) begin n_fail++; $display("FAIL rmid_sub_c2: got %h expected %h", obs, 12'hAFF); end
        tick();
        n_cmp++; if (obs !== 12'hEFF) begin n_fail++; $display("FAIL rmid_sub_c3: got %h expected %h", obs, 12'hEFF); end
        tick();
        n_cmp++; if (obs !== 12'h000) begin n_fail++; $display("FAIL rmid_sub_c4: got %h expected %h", obs, 12'h000); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul_backpressure();
        test_divmod(4'd6, 16'h008E);
        test_divmod(4'd7, 16'h0006);
        test_errors();
        test_busy_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
